// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment display encoder/decoder pair.
// Segment bit order on the 7-bit bus: seg[6]=a, seg[5]=b, seg[4]=c,
// seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g, all active-high.
package sevenseg_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_ERR   = 4'hF;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HOLD   = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational lookup from a segment pattern to its code.
// Blank is a legal pattern; anything not in the table is flagged illegal.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       illegal
);

  // Pattern table lookup; default catches every non-digit, non-blank pattern.
  always_comb begin
    code    = CODE_ERR;
    illegal = 1'b0;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code    = CODE_ERR;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Recovers per-digit codes from a multiplexed seven-segment bus and
// publishes them as one frame once every digit has been captured.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_SETTLE  | counting consecutive matching one-hot samples
// ST_HOLD    | current dwell already captured; wait for the bus to change
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    frame_valid,
  output logic                    err_pulse,
  output logic [7:0]              err_cnt
);

  localparam logic [7:0]            CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0]   s1_an, s2_an;
  logic [6:0]              s1_seg, s2_seg;
  logic                    an_onehot;
  logic                    match;
  logic [3:0]              dec_code;
  logic                    dec_illegal;
  scan_state_t             state;
  logic [7:0]              cnt;
  logic [NUM_DIGITS-1:0]   seen;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic                    frame_done;
  logic [4*NUM_DIGITS-1:0] digit_reg;
  logic [4*NUM_DIGITS-1:0] digit_next;

  // Two-stage sample pipeline; stability is judged between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_an  <= '0;
      s1_seg <= '0;
      s2_an  <= '0;
      s2_seg <= '0;
    end else begin
      s1_an  <= an;
      s1_seg <= seg;
      s2_an  <= s1_an;
      s2_seg <= s1_seg;
    end
  end

  assign an_onehot = (s1_an != '0) && ((s1_an & (s1_an - AN_ONE)) == '0);
  assign match     = (s1_an == s2_an) && (s1_seg == s2_seg) && an_onehot;

  sevenseg_pattern_decode u_decode (
    .pattern (s1_seg),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  // Candidate digit/seen update for a capture of the currently enabled digit.
  always_comb begin
    digit_next = digit_reg;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s1_an[i]) digit_next[4*i +: 4] = dec_code;
    end
  end

  assign seen_next  = seen | s1_an;
  assign frame_done = &seen_next;

  // Dwell FSM with capture, frame publish and error accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SETTLE;
      cnt         <= '0;
      seen        <= '0;
      digit_reg   <= '0;
      bcd_out     <= '0;
      frame_valid <= 1'b0;
      err_pulse   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= 1'b0;
      err_pulse   <= 1'b0;
      case (state)
        ST_SETTLE: begin
          if (!match) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            state     <= ST_HOLD;
            digit_reg <= digit_next;
            if (frame_done) begin
              bcd_out     <= digit_next;
              frame_valid <= 1'b1;
              seen        <= '0;
            end else begin
              seen <= seen_next;
            end
            if (dec_illegal) begin
              err_pulse <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          if (!match) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_SETTLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
